// File: rtl/pifo_pkg.sv
// Shared types and default widths for the PIFO register driver.
package pifo_pkg;

   localparam int L2_REG_WIDTH_DEF = 4;
   localparam int RANK_WIDTH_DEF   = 16;
   localparam int META_WIDTH_DEF   = 12;
   localparam int CNT_WIDTH_DEF    = 32;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [RANK_WIDTH_DEF-1:0] rank;
      logic [META_WIDTH_DEF-1:0] meta;
   } entry_t;

endpackage

// File: rtl/pifo_reg_driver_if.sv
// Stream-side and PIFO-side signals of the PIFO register driver.
interface pifo_reg_driver_if
   import pifo_pkg::*;
#(
   parameter int L2_REG_WIDTH = L2_REG_WIDTH_DEF,
   parameter int RANK_WIDTH   = RANK_WIDTH_DEF,
   parameter int META_WIDTH   = META_WIDTH_DEF,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF
);
   logic                    enq_valid;
   logic                    enq_ready;
   logic [RANK_WIDTH-1:0]   enq_rank;
   logic [META_WIDTH-1:0]   enq_meta;
   logic                    deq_valid;
   logic                    deq_ready;
   logic [RANK_WIDTH-1:0]   deq_rank;
   logic [META_WIDTH-1:0]   deq_meta;
   logic                    drop_valid;
   logic [RANK_WIDTH-1:0]   drop_rank;
   logic [META_WIDTH-1:0]   drop_meta;
   logic [CNT_WIDTH-1:0]    drop_cnt;
   logic                    pifo_insert;
   logic                    pifo_remove;
   logic [RANK_WIDTH-1:0]   pifo_rank_in;
   logic [META_WIDTH-1:0]   pifo_meta_in;
   logic                    pifo_full;
   logic                    pifo_valid_out;
   logic                    pifo_max_valid_out;
   logic [RANK_WIDTH-1:0]   pifo_rank_out;
   logic [META_WIDTH-1:0]   pifo_meta_out;
   logic [RANK_WIDTH-1:0]   pifo_max_rank_out;
   logic [META_WIDTH-1:0]   pifo_max_meta_out;
   logic [L2_REG_WIDTH:0]   pifo_num_entries;

   // slave: the driver block; master: scheduler plus PIFO register side
   modport slave (
      input  enq_valid, enq_rank, enq_meta, deq_ready,
      output enq_ready, deq_valid, deq_rank, deq_meta,
      output drop_valid, drop_rank, drop_meta, drop_cnt,
      output pifo_insert, pifo_remove, pifo_rank_in, pifo_meta_in,
      input  pifo_full, pifo_valid_out, pifo_max_valid_out,
      input  pifo_rank_out, pifo_meta_out, pifo_max_rank_out, pifo_max_meta_out,
      input  pifo_num_entries
   );

   modport master (
      output enq_valid, enq_rank, enq_meta, deq_ready,
      input  enq_ready, deq_valid, deq_rank, deq_meta,
      input  drop_valid, drop_rank, drop_meta, drop_cnt,
      input  pifo_insert, pifo_remove, pifo_rank_in, pifo_meta_in,
      output pifo_full, pifo_valid_out, pifo_max_valid_out,
      output pifo_rank_out, pifo_meta_out, pifo_max_rank_out, pifo_max_meta_out,
      output pifo_num_entries
   );

endinterface

// File: rtl/pifo_rr_arb2.sv
// Two-requester round-robin grant; req[0] is dequeue, req[1] is enqueue.
module pifo_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt,
   output logic       rr
);

   assign gnt[0] = req[0] && (!req[1] || !rr);
   assign gnt[1] = req[1] && (!req[0] ||  rr);

   // after a grant, priority moves to the other requester
   always_ff @(posedge clk) begin
      if (rst)      rr <= 1'b0;
      else if (upd) rr <= gnt[0];
   end

endmodule

// File: rtl/pifo_reg_driver.sv
// Drives one PIFO register from enqueue/dequeue streams with command spacing
// and full-register evict/drop handling.
//
//   state | meaning
//   IDLE  | commands may be issued to the PIFO
//   HOLD  | one-cycle gap after insert/remove; no commands, streams stalled
module pifo_reg_driver
   import pifo_pkg::*;
#(
   parameter int L2_REG_WIDTH = L2_REG_WIDTH_DEF,
   parameter int RANK_WIDTH   = RANK_WIDTH_DEF,
   parameter int META_WIDTH   = META_WIDTH_DEF,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   pifo_reg_driver_if.slave  bus
);

   localparam logic [L2_REG_WIDTH:0] CAP = (L2_REG_WIDTH+1)'(2**L2_REG_WIDTH);

   state_t                state, state_nxt;
   logic                  idle, full, stall;
   logic                  deq_req, enq_req, deq_gnt, enq_gnt, rr;
   logic                  ins, rem, evict, drop_in;
   logic                  drop_q;
   logic [RANK_WIDTH-1:0] drop_rank_q;
   logic [META_WIDTH-1:0] drop_meta_q;
   logic [CNT_WIDTH-1:0]  cnt_q;

   // outputs are forced to their reset values while rst is high
   assign idle    = (state == IDLE) && !rst;
   assign full    = bus.pifo_full || (bus.pifo_num_entries == CAP);
   assign stall   = full && !bus.pifo_max_valid_out;
   assign deq_req = idle && bus.pifo_valid_out && bus.deq_ready;
   assign enq_req = idle && bus.enq_valid && !stall;

   pifo_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({enq_req, deq_req}),
      .upd (deq_gnt || enq_gnt),
      .gnt ({enq_gnt, deq_gnt}),
      .rr  (rr)
   );

   always_comb begin
      state_nxt = state;
      ins       = 1'b0;
      rem       = 1'b0;
      evict     = 1'b0;
      drop_in   = 1'b0;
      case (state)
         IDLE: begin
            if (deq_gnt) begin
               rem = 1'b1;
            end else if (enq_gnt) begin
               if (!full) begin
                  ins = 1'b1;
               end else if (bus.enq_rank < bus.pifo_max_rank_out) begin
                  ins   = 1'b1;
                  evict = 1'b1;
               end else begin
                  drop_in = 1'b1;
               end
            end
            if (ins || rem) state_nxt = HOLD;
         end
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         drop_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         drop_q <= evict || drop_in;
         if ((evict || drop_in) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   // evict reports the displaced maximum; a rejected enqueue reports itself
   always_ff @(posedge clk) begin
      if (evict) begin
         drop_rank_q <= bus.pifo_max_rank_out;
         drop_meta_q <= bus.pifo_max_meta_out;
      end else if (drop_in) begin
         drop_rank_q <= bus.enq_rank;
         drop_meta_q <= bus.enq_meta;
      end
   end

   assign bus.enq_ready    = idle && !stall && !(deq_req && !rr);
   assign bus.deq_valid    = idle && bus.pifo_valid_out;
   assign bus.deq_rank     = bus.pifo_rank_out;
   assign bus.deq_meta     = bus.pifo_meta_out;
   assign bus.drop_valid   = drop_q && !rst;
   assign bus.drop_rank    = drop_rank_q;
   assign bus.drop_meta    = drop_meta_q;
   assign bus.drop_cnt     = cnt_q;
   assign bus.pifo_insert  = ins;
   assign bus.pifo_remove  = rem;
   assign bus.pifo_rank_in = bus.enq_rank;
   assign bus.pifo_meta_in = bus.enq_meta;

endmodule

// File: doc/pifo_reg_driver.md
# pifo_reg_driver

Stream-side controller that drives a PIFO register on behalf of the switch datapath. Enqueue descriptors arrive on a valid/ready stream and are inserted. The current minimum entry is offered as a valid/ready dequeue stream. Entries rejected or displaced by a full register are reported on a drop port. The block sits between the packet scheduler logic and one PIFO register instance, and it enforces that register's command spacing and full/evict rules.

## Interface
- L2_REG_WIDTH, 4: log2 of PIFO capacity; capacity is 2**L2_REG_WIDTH.
- RANK_WIDTH, 16: rank width.
- META_WIDTH, 12: metadata width.
- CNT_WIDTH, 32: drop counter width.

Reset is rst, synchronous, active-high; the clock is clk.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset; the PIFO register is reset by the same signal.
- enq_valid / enq_ready  in / out  1 / 1  enqueue handshake
- enq_rank / enq_meta  in  RANK_WIDTH / META_WIDTH  enqueue payload
- deq_valid / deq_ready  out / in  1 / 1  dequeue handshake
- deq_rank / deq_meta  out  RANK_WIDTH / META_WIDTH  current minimum entry
- drop_valid  out  1  one-cycle pulse; no backpressure
- drop_rank / drop_meta  out  RANK_WIDTH / META_WIDTH  dropped entry
- drop_cnt  out  CNT_WIDTH  total drops; saturates at all-ones
- pifo_insert / pifo_remove  out  1 / 1  single-cycle commands to the PIFO
- pifo_rank_in / pifo_meta_in  out  RANK_WIDTH / META_WIDTH  insert payload
- pifo_full / pifo_valid_out / pifo_max_valid_out  in  1 each  PIFO status
- pifo_rank_out / pifo_meta_out  in  RANK_WIDTH / META_WIDTH  PIFO minimum entry
- pifo_max_rank_out / pifo_max_meta_out  in  RANK_WIDTH / META_WIDTH  PIFO maximum entry
- pifo_num_entries  in  L2_REG_WIDTH+1  PIFO occupancy

## Operation
- FSM states:
  - IDLE: commands may be issued.
  - HOLD: exactly one cycle, entered after any pifo_insert or pifo_remove; no commands, enq_ready=0, deq_valid=0. Always returns to IDLE.
- PIFO contract (fixed): after a command in cycle T, pifo_valid_out and pifo_max_valid_out are 0 in T+1. In T+2 they read 1 if occupancy > 0. Min/max outputs are valid only while the corresponding valid is 1.
- deq path:
  - deq_valid = IDLE && pifo_valid_out.
  - deq_rank and deq_meta pass through combinationally from pifo_rank_out and pifo_meta_out.
  - An accepted deq (valid && ready && granted) pulses pifo_remove in the same cycle.
- enq path (IDLE, enq granted, enq_valid):
  - Not full: pulse pifo_insert with enq_rank/enq_meta.
  - Full and pifo_max_valid_out=0: enq_ready=0 (stall).
  - Full, max valid, enq_rank < pifo_max_rank_out (strict): pulse pifo_insert. Also pulse drop_valid next cycle with the registered max rank/meta (the displaced entry).
  - Full, enq_rank >= max: no insert, no HOLD. Enqueue is consumed, and drop_valid pulses next cycle with the incoming rank/meta.
- Arbitration when a deq and an enq are both possible in IDLE:
  - Round-robin bit rr: 0 favours deq, 1 favours enq. rr flips to the loser after each granted command.
  - rr resets to 0.
  - Insert and remove are never issued in the same cycle.
- enq_ready is combinational: IDLE && not (deq_valid && deq_ready && deq wins) && not stalled. It may depend on deq_ready but not on enq_valid.
- drop_cnt increments on every drop_valid pulse and saturates at all-ones.

## Timing
- Reset values:
  - enq_ready=0, deq_valid=0, drop_valid=0, drop_cnt=0, pifo_insert=0, pifo_remove=0, FSM=IDLE, rr=0.
  - deq/drop payloads are don't-care.
- Enqueue-to-dequeue latency into an empty PIFO: insert at T, deq_valid at T+2.
- Peak throughput: one PIFO command per 2 cycles. A drop-incoming enqueue costs 1 cycle.
- Drop pulse: exactly 1 cycle, at T+1 relative to the enq handshake.
- Reset mid-HOLD: the FSM returns to IDLE; any pending drop pulse is suppressed.

## Structure
- Shared package pifo_pkg holds:
  - default RANK_WIDTH/META_WIDTH/L2_REG_WIDTH constants;
  - FSM state type (IDLE, HOLD);
  - the entry struct {rank, meta}.
- One sub-module, pifo_rr_arb2: a 2-requester round-robin grant with an rr register and an update strobe.
- Everything else is in pifo_reg_driver.

## Test plan
Bench uses L2_REG_WIDTH=2 (4 entries) with a real PIFO register instance.

1. Empty; enqueue rank 7 at T. Required: pifo_insert at T, enq_ready=0 at T+1, deq_valid=1 with deq_rank=7 at T+2.
2. Enqueue ranks 9,3,5,1 with deq_ready=0, then deq_ready=1. Required: dequeues 1,3,5,9; each pifo_remove is followed by a cycle with deq_valid=0.
3. Full {1,3,5,9}; enqueue rank 4. Required: insert issued; drop_valid=1 next cycle with drop_rank=9; drop_cnt=1; subsequent dequeues are 1,3,4,5.
4. Full {1,3,5,9}; enqueue rank 9, then rank 12. Required: no pifo_insert; two drop pulses with ranks 9 and 12; drop_cnt=2.
5. enq_valid and deq_ready held high continuously from 2 entries. Required: pifo_insert/pifo_remove alternate, never in the same cycle, starting with remove (rr=0).
6. rst asserted in the HOLD cycle after a full-evict insert. Required: no drop pulse, all outputs at reset values next cycle, drop_cnt=0.
